// File: rtl/bram_asym.sv
// Simple dual-port RAM with independent write and read widths on one clock.
// Storage is split into RATIO min-width banks so wide accesses touch every bank in one cycle.
module bram_asym_bank #(
  parameter int W  = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  q
);
  logic [W-1:0] mem [2**AW];

  // Plain read-before-write port pair; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

module bram_asym #(
  parameter int WRITE_WIDTH      = 32,
  parameter int READ_WIDTH       = 64,
  parameter int WRITE_ADDR_WIDTH = 10,
  parameter int READ_ADDR_WIDTH  = 9,
  parameter int OUT_REG          = 1,
  parameter int RDW_MODE         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_valid,
  input  logic [WRITE_ADDR_WIDTH-1:0] w_addr,
  input  logic [WRITE_WIDTH-1:0]      w_data,
  input  logic                        r_valid,
  input  logic [READ_ADDR_WIDTH-1:0]  r_addr,
  output logic [READ_WIDTH-1:0]       r_data,
  output logic                        r_data_valid
);
  localparam int MIN_W     = (WRITE_WIDTH < READ_WIDTH) ? WRITE_WIDTH : READ_WIDTH;
  localparam int MAX_W     = (WRITE_WIDTH < READ_WIDTH) ? READ_WIDTH : WRITE_WIDTH;
  localparam int RATIO     = MAX_W / MIN_W;
  localparam int WIDE_AW   = (WRITE_ADDR_WIDTH < READ_ADDR_WIDTH) ? WRITE_ADDR_WIDTH : READ_ADDR_WIDTH;
  localparam int LOG_RATIO = (WRITE_ADDR_WIDTH < READ_ADDR_WIDTH) ? READ_ADDR_WIDTH - WRITE_ADDR_WIDTH
                                                                  : WRITE_ADDR_WIDTH - READ_ADDR_WIDTH;
  localparam bit W_WIDE    = WRITE_WIDTH >= READ_WIDTH;
  localparam bit R_WIDE    = READ_WIDTH >= WRITE_WIDTH;
  localparam int STAGES    = (OUT_REG != 0) ? 2 : 1;

  if ((MAX_W % MIN_W) != 0 || (RATIO & (RATIO - 1)) != 0 || (1 << LOG_RATIO) != RATIO) begin : g_bad_ratio
    $error("bram_asym: width ratio must be a power of two matching the address width difference");
  end
  if ((longint'(WRITE_WIDTH) << WRITE_ADDR_WIDTH) != (longint'(READ_WIDTH) << READ_ADDR_WIDTH)) begin : g_bad_cap
    $error("bram_asym: write and read capacities differ");
  end

  logic                         w_en, r_en;
  logic [RATIO-1:0]             bank_we;
  logic [WIDE_AW-1:0]           bank_wa, bank_ra;
  logic [RATIO-1:0][MIN_W-1:0]  bank_wd, bank_q, lane_out;
  logic [READ_WIDTH-1:0]        rd_mux;
  logic [STAGES-1:0]            vld_pipe;

  assign w_en = w_valid & ~rst;
  assign r_en = r_valid & ~rst;

  // Write side: a wide word hits every bank, a narrow word hits the bank picked by its low bits.
  if (W_WIDE) begin : g_wwide
    assign bank_wa = w_addr;
    assign bank_wd = w_data;
    assign bank_we = {RATIO{w_en}};
  end else begin : g_wnarrow
    assign bank_wa = w_addr[WRITE_ADDR_WIDTH-1:LOG_RATIO];
    assign bank_wd = {RATIO{w_data}};
    always_comb begin
      bank_we = '0;
      bank_we[w_addr[LOG_RATIO-1:0]] = w_en;
    end
  end

  if (R_WIDE) begin : g_rwide
    assign bank_ra = r_addr;
  end else begin : g_rnarrow
    assign bank_ra = r_addr[READ_ADDR_WIDTH-1:LOG_RATIO];
  end

  for (genvar b = 0; b < RATIO; b++) begin : g_bank
    bram_asym_bank #(.W(MIN_W), .AW(WIDE_AW)) u_bank (
      .clk (clk),
      .we  (bank_we[b]),
      .wa  (bank_wa),
      .wd  (bank_wd[b]),
      .re  (r_en),
      .ra  (bank_ra),
      .q   (bank_q[b])
    );
  end

  // New-data mode patches colliding lanes after the RAM, using the write captured alongside the read.
  if (RDW_MODE != 0) begin : g_rdw_new
    logic [RATIO-1:0]            coll, coll_q;
    logic [RATIO-1:0][MIN_W-1:0] wd_q;

    assign coll = bank_we & {RATIO{bank_wa == bank_ra}};

    always_ff @(posedge clk) begin
      if (rst) begin
        coll_q <= '0;
        wd_q   <= '0;
      end else if (r_en) begin
        coll_q <= coll;
        wd_q   <= bank_wd;
      end
    end

    for (genvar b = 0; b < RATIO; b++) begin : g_lane
      assign lane_out[b] = coll_q[b] ? wd_q[b] : bank_q[b];
    end
  end else begin : g_rdw_old
    assign lane_out = bank_q;
  end

  if (R_WIDE) begin : g_mux_wide
    assign rd_mux = lane_out;
  end else begin : g_mux_narrow
    logic [LOG_RATIO-1:0] r_sel_q;

    always_ff @(posedge clk) begin
      if (rst)       r_sel_q <= '0;
      else if (r_en) r_sel_q <= r_addr[LOG_RATIO-1:0];
    end

    assign rd_mux = lane_out[r_sel_q];
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= STAGES'({vld_pipe, r_en});
  end

  assign r_data_valid = vld_pipe[STAGES-1];

  if (OUT_REG != 0) begin : g_oreg
    logic [READ_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst)              dout_q <= '0;
      else if (vld_pipe[0]) dout_q <= rd_mux;
    end

    assign r_data = dout_q;
  end else begin : g_noreg
    // Bank outputs only move on accepted reads; this flag forces zero between reset and the first read.
    logic zero_q;

    always_ff @(posedge clk) begin
      if (rst)       zero_q <= 1'b1;
      else if (r_en) zero_q <= 1'b0;
    end

    assign r_data = zero_q ? '0 : rd_mux;
  end
endmodule

// File: doc/bram_asym.md
Name: bram_asym

Overview:
- Simple dual-port block RAM with independent write and read widths: one write port, one read port, single clock.
- Generalises the plain symmetric BRAM used by the Cicero engine's instruction/data memories.
- Narrow writes (e.g. 32-bit words from the host loader) fill wide read words (e.g. 64-bit words fetched by the core), or the reverse.
- Adds optional output register, read-data valid flag and a selectable read-during-write policy.

Parameters:
- WRITE_WIDTH, 32, write data width in bits.
- READ_WIDTH, 64, read data width in bits.
- WRITE_ADDR_WIDTH, 10, write address width.
- READ_ADDR_WIDTH, 9, read address width.
- OUT_REG, 1, 0 = read latency 1, 1 = extra output register stage (latency 2).
- RDW_MODE, 0, read-during-write collision policy: 0 = return old data, 1 = return new data.
- Constraints (elaboration error if violated):
  - max(W,R)/min(W,R) is a power of two, called RATIO.
  - WRITE_WIDTH*2**WRITE_ADDR_WIDTH == READ_WIDTH*2**READ_ADDR_WIDTH.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- w_valid  input  1  write strobe.
- w_addr  input  WRITE_ADDR_WIDTH  write address in write-word units.
- w_data  input  WRITE_WIDTH  write data.
- r_valid  input  1  read request.
- r_addr  input  READ_ADDR_WIDTH  read address in read-word units.
- r_data  output  READ_WIDTH  read data.
- r_data_valid  output  1  high for one cycle when r_data carries the result of a request.

Behaviour:
- Storage:
  - Array of min-width lanes, depth max(2**WRITE_ADDR_WIDTH, 2**READ_ADDR_WIDTH); implemented in M9K, no reset of contents.
  - Wide word at address A maps to lanes {A, i}, i = 0..RATIO-1.
  - Lane i occupies bits [(i+1)*minW-1 : i*minW] of the wide word (lane 0 = LSBs).
- Write:
  - w_valid=1 and rst=0 at edge: the addressed word is committed.
  - If write is wide, all RATIO lanes are written in the same cycle.
  - Writes while rst=1 are suppressed.
- Read:
  - r_valid=1 and rst=0 at edge captures the addressed word.
  - OUT_REG=0: r_data and r_data_valid update on that edge (latency 1).
  - OUT_REG=1: updated one edge later (latency 2).
  - Back-to-back reads accepted every cycle (full throughput, no stall).
- Hold: r_data holds its last value when no new result arrives. r_data_valid is 0 in any cycle without a fresh result.
- Collision (read and write same edge, overlapping lanes):
  - Overlap means any write lane address equals any read lane address.
  - RDW_MODE=0: overlapping lanes return the pre-write contents.
  - RDW_MODE=1: overlapping lanes return w_data's lane; non-overlapping lanes return stored contents.
  - Implemented by registering the collision mask and write data and muxing after the RAM read.
  - Stored contents always updated regardless of mode.
- Reset:
  - rst=1 at an edge: r_data←0, r_data_valid←0, OUT_REG pipeline stage and collision registers cleared.
  - A read in flight in the OUT_REG stage when rst rises is dropped; no r_data_valid pulse follows.
  - First request accepted on the edge after rst falls.
- Address wrap: none. Addresses are exact-width, no out-of-range case exists.
- Symmetric case (READ_WIDTH==WRITE_WIDTH, RATIO=1) must work and is functionally a plain dual-port RAM plus the added features.

Test Plan:
- Narrow-write/wide-read, defaults, OUT_REG=0:
  - Stimulus: write 0x11111111 @4, 0x22222222 @5; read @2.
  - Required: one edge later r_data=0x2222222211111111, r_data_valid=1 for exactly one cycle.
- Wide-write/narrow-read (WRITE_WIDTH=64, READ_WIDTH=32, WRITE_ADDR_WIDTH=9, READ_ADDR_WIDTH=10):
  - Stimulus: write 0xAABBCCDD00112233 @7; read @14 then @15 back-to-back.
  - Required: 0x00112233 then 0xAABBCCDD on consecutive cycles, r_data_valid high both cycles.
- Collision, RDW_MODE=0 vs 1:
  - Stimulus: preload @2 = 0x00000000_00000000; same edge write 0xDEADBEEF @5 and read @2.
  - Required: mode 0 returns 0x0000000000000000; mode 1 returns 0xDEADBEEF00000000.
  - Follow-up: a subsequent read @2 returns 0xDEADBEEF00000000 in both modes.
- OUT_REG=1 latency and throughput:
  - Stimulus: reads @0,@1,@2 on consecutive edges.
  - Required: results appear 2 edges after each request, 3 consecutive r_data_valid pulses, r_data holds after the last.
- Reset mid-operation, OUT_REG=1:
  - Stimulus: read @3; assert rst on the next edge.
  - Required: r_data=0, r_data_valid never pulses for that read.
  - Also: memory @3 still readable after reset; a w_valid during rst leaves memory unchanged.
- Idle hold:
  - Stimulus: read @1, then r_valid=0 for 10 cycles.
  - Required: r_data stays constant, r_data_valid=0 throughout.
